// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with mid-bit sampling and a valid/ack byte handoff.
// Latency: rx_valid rises 3 + (CLKS_PER_BIT-1)/2 + 9*CLKS_PER_BIT cycles after Rx is first sampled low.
// Backpressure: none on the wire; an unacknowledged byte is overwritten by the next good frame and flags overrun.
//
// Ports:
//   CLK          system clock, all state on the rising edge
//   reset        asynchronous active-low reset
//   Rx           serial line, idle high, asynchronous to CLK
//   uart_select  enables start-bit detection while idle
//   rx_ack       consumer acknowledge for RX_Data
//   RX_Data      last received byte
//   rx_valid     RX_Data holds an unacknowledged byte
//   rx_busy      receiver is inside a frame (or waiting out a break)
//   frame_err    last frame ended with a low stop bit
//   overrun      a byte was overwritten before it was acknowledged (sticky)
module uart_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int CNT_W        = 16
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       Rx,
  input  logic       uart_select,
  input  logic       rx_ack,
  output logic [7:0] RX_Data,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       overrun
);

  localparam logic [CNT_W-1:0] HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } state_t;

  state_t           state,   state_n;
  logic [CNT_W-1:0] cnt,     cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shreg,   shreg_n;
  logic [7:0]       data_n;
  logic             valid_n;
  logic             ferr_n;
  logic             overrun_n;
  logic             ack_acc;

  // Two-flop synchroniser; the line idles high so both flops reset to 1.
  logic rx_meta;
  logic rx_s;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= Rx;
      rx_s    <= rx_meta;
    end
  end

  // State register
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      RX_Data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bit_idx   <= bit_idx_n;
      shreg     <= shreg_n;
      RX_Data   <= data_n;
      rx_valid  <= valid_n;
      frame_err <= ferr_n;
      overrun   <= overrun_n;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    data_n    = RX_Data;
    ferr_n    = frame_err;
    // An acknowledge only counts while a byte is actually pending.
    ack_acc   = rx_ack & rx_valid;
    valid_n   = rx_valid & ~ack_acc;
    overrun_n = overrun & ~ack_acc;

    case (state)
      ST_IDLE: begin
        if (!rx_s && uart_select) begin
          state_n = ST_START;
          cnt_n   = '0;
        end
      end

      ST_START: begin
        if (cnt == HALF) begin
          cnt_n = '0;
          if (!rx_s) begin
            state_n   = ST_DATA;
            bit_idx_n = '0;
          end else begin
            // Line went back high before mid-bit: treat as a glitch.
            state_n = ST_IDLE;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      ST_DATA: begin
        if (cnt == LAST) begin
          cnt_n     = '0;
          // LSB arrives first, so shift right and enter at the MSB.
          shreg_n   = {rx_s, shreg[7:1]};
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
            state_n = ST_STOP;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      ST_STOP: begin
        if (cnt == LAST) begin
          cnt_n = '0;
          if (rx_s) begin
            data_n  = shreg;
            valid_n = 1'b1;
            ferr_n  = 1'b0;
            // Overwriting a pending byte is an overrun unless it is being
            // acknowledged on this very edge.
            if (rx_valid && !rx_ack) begin
              overrun_n = 1'b1;
            end
            state_n = ST_IDLE;
          end else begin
            ferr_n  = 1'b1;
            state_n = ST_BREAK;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      ST_BREAK: begin
        // Hold off until the line recovers so a stuck-low line cannot
        // masquerade as a stream of start bits.
        if (rx_s) begin
          state_n = ST_IDLE;
        end
      end

      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  assign rx_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx with a byte scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_rx;

  localparam int C = 16;

  logic       CLK;
  logic       reset;
  logic       Rx;
  logic       uart_select;
  logic       rx_ack;
  logic [7:0] RX_Data;
  logic       rx_valid;
  logic       rx_busy;
  logic       frame_err;
  logic       overrun;

  int n_assert;
  int n_fail;
  int rise_cyc;
  logic [7:0] exp_q[$];

  uart_rx #(.CLKS_PER_BIT(C), .CNT_W(16)) dut (
    .CLK        (CLK),
    .reset      (reset),
    .Rx         (Rx),
    .uart_select(uart_select),
    .rx_ack     (rx_ack),
    .RX_Data    (RX_Data),
    .rx_valid   (rx_valid),
    .rx_busy    (rx_busy),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      Rx     = 1'b1;
      rx_ack = 1'b0;
    end
  endtask

  // Drives one frame (start, 8 data LSB first, stop) for up to max_cyc cycles.
  // rx_ack is pulsed on cycle ack_cyc (cycle 0 = first edge sampling start).
  // rise_cyc records the cycle on which rx_valid went 0->1.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input int max_cyc, input int ack_cyc);
    logic [9:0] bits;
    logic       prev_v;
    bits     = {stop_bit, b, 1'b0};
    rise_cyc = -1;
    if (stop_bit && max_cyc >= 10 * C && uart_select) exp_q.push_back(b);
    for (int i = 0; i < 10 * C && i < max_cyc; i++) begin
      @(negedge CLK);
      Rx     = bits[i / C];
      rx_ack = (i == ack_cyc);
      prev_v = rx_valid;
      @(posedge CLK);
      #1;
      if (!prev_v && rx_valid && rise_cyc < 0) rise_cyc = i;
    end
    rx_ack = 1'b0;
  endtask

  // Pops the scoreboard and checks the delivered byte.
  task automatic check_rx(input string tag);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s: scoreboard empty, observed %0h", tag, RX_Data);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_data"}, 32'(RX_Data), 32'(e));
      chk({tag, "_valid"}, 32'(rx_valid), 32'd1);
    end
  endtask

  // Accepted acknowledge: rx_valid and overrun clear on the same edge.
  task automatic do_ack(input string tag);
    @(negedge CLK);
    rx_ack = 1'b1;
    @(posedge CLK);
    #1;
    chk({tag, "_valid_clr"}, 32'(rx_valid), 32'd0);
    chk({tag, "_ovr_clr"}, 32'(overrun), 32'd0);
    @(negedge CLK);
    rx_ack = 1'b0;
  endtask

  initial begin
    logic busy_seen;
    n_assert    = 0;
    n_fail      = 0;
    reset       = 1'b0;
    Rx          = 1'b1;
    uart_select = 1'b1;
    rx_ack      = 1'b0;
    #22;
    chk("rst_data", 32'(RX_Data), 32'h00);
    chk("rst_valid", 32'(rx_valid), 32'd0);
    chk("rst_busy", 32'(rx_busy), 32'd0);
    chk("rst_ferr", 32'(frame_err), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    @(negedge CLK);
    reset = 1'b1;
    idle(4);

    // 1: basic byte, latency, handshake
    send_frame(8'hA5, 1'b1, 10 * C, -1);
    check_rx("t1");
    chk("t1_latency_ok", 32'((rise_cyc >= 153 && rise_cyc <= 155) ? 1 : 0), 32'd1);
    chk("t1_ferr", 32'(frame_err), 32'd0);
    chk("t1_ovr", 32'(overrun), 32'd0);
    do_ack("t1");
    // ack with nothing pending is ignored
    do_ack("t1_idle_ack");
    chk("t1_idle_ack_data", 32'(RX_Data), 32'hA5);

    // 2: 4-cycle glitch
    busy_seen = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(negedge CLK);
      Rx = (i < 4) ? 1'b0 : 1'b1;
      @(posedge CLK);
      #1;
      if (rx_busy) busy_seen = 1'b1;
    end
    chk("t2_busy_seen", 32'(busy_seen), 32'd1);
    chk("t2_busy_end", 32'(rx_busy), 32'd0);
    chk("t2_valid", 32'(rx_valid), 32'd0);
    chk("t2_ferr", 32'(frame_err), 32'd0);
    chk("t2_data", 32'(RX_Data), 32'hA5);

    // 3: framing error, break hold, recovery
    send_frame(8'h3C, 1'b0, 10 * C, -1);
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      Rx = 1'b0;
    end
    @(posedge CLK);
    #1;
    chk("t3_ferr", 32'(frame_err), 32'd1);
    chk("t3_valid", 32'(rx_valid), 32'd0);
    chk("t3_busy_break", 32'(rx_busy), 32'd1);
    chk("t3_data_kept", 32'(RX_Data), 32'hA5);
    idle(6);
    chk("t3_busy_idle", 32'(rx_busy), 32'd0);
    send_frame(8'h55, 1'b1, 10 * C, -1);
    check_rx("t3");
    chk("t3_ferr_clr", 32'(frame_err), 32'd0);
    do_ack("t3");

    // 4: overrun
    send_frame(8'h11, 1'b1, 10 * C, -1);
    check_rx("t4a");
    chk("t4a_ovr", 32'(overrun), 32'd0);
    send_frame(8'h22, 1'b1, 10 * C, -1);
    check_rx("t4b");
    chk("t4b_ovr", 32'(overrun), 32'd1);
    do_ack("t4");

    // 5: ack coincident with the stop-bit edge of the next byte
    send_frame(8'h66, 1'b1, 10 * C, -1);
    check_rx("t5a");
    send_frame(8'h77, 1'b1, 10 * C, 154);
    check_rx("t5b");
    chk("t5_ovr", 32'(overrun), 32'd0);

    // 6: reset in DATA bit 4, then recovery and uart_select gating
    send_frame(8'hFF, 1'b1, 5 * C + 8, -1);
    chk("t6_busy_pre", 32'(rx_busy), 32'd1);
    @(negedge CLK);
    reset = 1'b0;
    #1;
    chk("t6_rst_data", 32'(RX_Data), 32'h00);
    chk("t6_rst_valid", 32'(rx_valid), 32'd0);
    chk("t6_rst_busy", 32'(rx_busy), 32'd0);
    chk("t6_rst_ferr", 32'(frame_err), 32'd0);
    chk("t6_rst_ovr", 32'(overrun), 32'd0);
    idle(3);
    @(negedge CLK);
    reset = 1'b1;
    idle(4);
    chk("t6_no_partial", 32'(rx_valid), 32'd0);
    send_frame(8'h0F, 1'b1, 10 * C, -1);
    check_rx("t6");
    do_ack("t6");
    uart_select = 1'b0;
    busy_seen   = 1'b0;
    send_frame(8'h99, 1'b1, 10 * C, -1);
    chk("t6_sel_valid", 32'(rx_valid), 32'd0);
    chk("t6_sel_data", 32'(RX_Data), 32'h0F);
    chk("t6_sel_busy", 32'(rx_busy), 32'd0);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
